// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the unified-memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RESP      = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between fetch, data-access, memory and the arbiter.
// Handshakes: a requester raises *_req with a stable payload and keeps it
// until the one-cycle *_gnt pulse; responses are one-cycle *_rvalid pulses
// and *_rdata is only meaningful while rvalid is high. Toward memory,
// mem_req and its payload stay stable until the cycle mem_ready is high;
// mem_rvalid returns read data later.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [BE_W-1:0]   dm_be;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    // Requester/memory side.
    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/mem_arb_select.sv
// Grant decision: data first, but fetch gets one turn after a run of
// MAX_DATA_STREAK data grants taken while fetch was waiting.
module mem_arb_select
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic if_flush,
    input  logic grant_en,
    output logic grant_if,
    output logic grant_dm
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    logic [SW-1:0] streak;
    logic          if_ok;
    logic          fetch_turn;

    // A flushed fetch request does not compete; fetch overrides data only at a full streak.
    always_comb begin
        if_ok      = if_req && !if_flush;
        fetch_turn = if_ok && (streak == STREAK_MAX);
        grant_dm   = grant_en && dm_req && !fetch_turn;
        grant_if   = grant_en && if_ok && (!dm_req || fetch_turn);
    end

    // Count data grants that made a waiting fetch wait longer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_if) begin
            streak <= '0;
        end else if (grant_dm) begin
            if (!if_req) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + SW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// One transaction at a time; a taken branch can squash an in-flight fetch
// response while the memory access itself still runs to completion.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus,
    output state_t         dbg_state
);

    state_t            state;
    state_t            state_next;
    owner_t            owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              first_q;
    logic              flushed_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              grant_if;
    logic              grant_dm;

    mem_arb_select #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_select (
        .clk      (clk),
        .rst      (rst),
        .if_req   (bus.if_req),
        .dm_req   (bus.dm_req),
        .if_flush (bus.if_flush),
        .grant_en (state == IDLE),
        .grant_if (grant_if),
        .grant_dm (grant_dm)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: writes finish on mem_ready, reads wait for mem_rvalid.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (grant_if || grant_dm) state_next = ISSUE;
            ISSUE:     if (bus.mem_ready) state_next = we_q ? RESP : WAIT_RESP;
            WAIT_RESP: if (bus.mem_rvalid) state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Capture the winner's payload at the granting edge; fetch is a full-word read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (grant_dm) begin
            owner_q <= OWN_DM;
            we_q    <= bus.dm_we;
            addr_q  <= bus.dm_addr;
            wdata_q <= bus.dm_wdata;
            be_q    <= bus.dm_be;
        end else if (grant_if) begin
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= bus.if_addr;
            wdata_q <= '0;
            be_q    <= '1;
        end
    end

    // first_q marks the first ISSUE cycle; flushed_q remembers a squash until IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q   <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            first_q <= grant_if || grant_dm;
            if (state == IDLE)
                flushed_q <= 1'b0;
            else if (bus.if_flush && owner_q == OWN_IF)
                flushed_q <= 1'b1;
        end
    end

    // Response data registers; each holds its last value between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else if (state == WAIT_RESP && bus.mem_rvalid) begin
            if (owner_q == OWN_IF) if_rdata_q <= bus.mem_rdata;
            else                   dm_rdata_q <= bus.mem_rdata;
        end else if (state == ISSUE && bus.mem_ready && we_q) begin
            dm_rdata_q <= '0;
        end
    end

    // Control outputs decode straight from state so reset clears them at once.
    assign bus.if_gnt    = (state == ISSUE) && first_q && (owner_q == OWN_IF);
    assign bus.dm_gnt    = (state == ISSUE) && first_q && (owner_q == OWN_DM);
    assign bus.if_rvalid = (state == RESP) && (owner_q == OWN_IF) && !flushed_q && !bus.if_flush;
    assign bus.dm_rvalid = (state == RESP) && (owner_q == OWN_DM);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_req   = (state == ISSUE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign dbg_state     = state;

endmodule
